// File: rtl/linear_seq_ctrl.sv
// linear_seq_ctrl: layer sequencer for the shared linear engine.
// Steps through 1..MAX_LAYERS layers: selects the weight bank, clears and enables
// the engine, waits for a fresh rising edge of lin_done, captures the result and
// feeds it back as the next layer's input.
// Optional feature: define LINSEQ_TIMEOUT_EN to abort a layer that runs for
// TIMEOUT_CYC cycles without a lin_done edge (err pulse, back to IDLE).
`timescale 1ns/1ps

module linear_seq_ctrl #(
  parameter int MAX_LAYERS  = 8,
  parameter int WLOAD_CYC   = 2,
  parameter int TIMEOUT_CYC = 1024,
  localparam int LW         = $clog2(MAX_LAYERS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] num_layers,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] layer_idx,
  output logic          in_sel,
  output logic          lin_rst,
  output logic          lin_enable,
  input  logic          lin_done,
  output logic          out_latch
);

  localparam int WW = (WLOAD_CYC < 2) ? 1 : $clog2(WLOAD_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_FIN
  } state_t;

  state_t        state;
  logic [LW-1:0] num_q;
  logic [WW-1:0] wait_cnt;
  logic          lin_done_p1;
  logic          done_edge;

`ifdef LINSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] run_cnt;
`else
  // Without the watchdog the timeout length has no effect; keep it referenced.
  if (TIMEOUT_CYC < 1) begin : g_unused_timeout
  end
`endif

  // A level already high on RUN entry was registered into lin_done_p1, so only a fresh rise counts.
  assign done_edge = lin_done & ~lin_done_p1;

  // Sequencer FSM; every output is registered and follows the state it is set for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      num_q       <= '0;
      wait_cnt    <= '0;
      lin_done_p1 <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      layer_idx   <= '0;
      in_sel      <= 1'b0;
      lin_rst     <= 1'b0;
      lin_enable  <= 1'b0;
      out_latch   <= 1'b0;
`ifdef LINSEQ_TIMEOUT_EN
      run_cnt     <= '0;
`endif
    end else begin
      lin_done_p1 <= lin_done;
      done        <= 1'b0;
      err         <= 1'b0;
      out_latch   <= 1'b0;
      case (state)
        S_IDLE: begin
          lin_rst <= 1'b0;
          if (start) begin
            if (num_layers == '0 || num_layers > LW'(MAX_LAYERS)) begin
              err <= 1'b1;
            end else begin
              num_q     <= num_layers;
              layer_idx <= '0;
              in_sel    <= 1'b0;
              wait_cnt  <= '0;
              busy      <= 1'b1;
              lin_rst   <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (wait_cnt == WW'(WLOAD_CYC - 1)) begin
            lin_rst    <= 1'b0;
            lin_enable <= 1'b1;
`ifdef LINSEQ_TIMEOUT_EN
            run_cnt    <= '0;
`endif
            state      <= S_RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (done_edge) begin
            lin_enable <= 1'b0;
            out_latch  <= 1'b1;
            state      <= S_CAPTURE;
          end
`ifdef LINSEQ_TIMEOUT_EN
          else if (run_cnt == TW'(TIMEOUT_CYC - 1)) begin
            lin_enable <= 1'b0;
            lin_rst    <= 1'b1;
            err        <= 1'b1;
            busy       <= 1'b0;
            in_sel     <= 1'b0;
            state      <= S_IDLE;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
`endif
        end
        S_CAPTURE: begin
          if (layer_idx == num_q - LW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            layer_idx <= layer_idx + 1'b1;
            in_sel    <= 1'b1;
            wait_cnt  <= '0;
            lin_rst   <= 1'b1;
            state     <= S_LOAD;
          end
        end
        S_FIN: begin
          in_sel <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_linear_seq_ctrl.sv
// Directed bench for linear_seq_ctrl with a small delayed-done engine model.
`timescale 1ns/1ps

module tb_linear_seq_ctrl;

  localparam int MAX_LAYERS  = 8;
  localparam int WLOAD_CYC   = 2;
  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_layers = '0;
  logic       busy, done, err, in_sel, lin_rst, lin_enable, out_latch;
  logic [3:0] layer_idx;
  logic       lin_done;

  // Engine model: done rises after eng_dly enabled cycles; eng_dly==0 never finishes.
  int   eng_dly = 1;
  int   e_cnt;
  logic e_done;
  logic ovr_en = 1'b0;
  logic ovr_val = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  linear_seq_ctrl #(
    .MAX_LAYERS (MAX_LAYERS),
    .WLOAD_CYC  (WLOAD_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_layers(num_layers),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .layer_idx (layer_idx),
    .in_sel    (in_sel),
    .lin_rst   (lin_rst),
    .lin_enable(lin_enable),
    .lin_done  (lin_done),
    .out_latch (out_latch)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst || lin_rst) begin
      e_cnt  <= 0;
      e_done <= 1'b0;
    end else if (lin_enable && !e_done && eng_dly != 0) begin
      if (e_cnt == eng_dly - 1) e_done <= 1'b1;
      else e_cnt <= e_cnt + 1;
    end
  end

  assign lin_done = ovr_en ? ovr_val : e_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy,done,err,in_sel,lin_rst,lin_enable,out_latch,layer_idx}
  function automatic logic [31:0] outs();
    return {21'b0, busy, done, err, in_sel, lin_rst, lin_enable, out_latch, layer_idx};
  endfunction

  // Runs one inference; cycle 0 is the start cycle, results are cycle numbers/records.
  task automatic run_job(input logic [3:0] n, input int dly, input bit inject,
                         output int done_cyc, output int latches,
                         output logic [11:0] idx_seq, output logic [2:0] sel_seq);
    int cyc;
    num_layers = n;
    eng_dly    = dly;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    cyc      = 1;
    done_cyc = -1;
    latches  = 0;
    idx_seq  = '0;
    sel_seq  = '0;
    while (cyc < 300) begin
      if (inject && cyc == 5) begin
        start      = 1'b1;
        num_layers = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (out_latch) begin
        if (latches < 3) begin
          idx_seq[latches*4 +: 4] = layer_idx;
          sel_seq[latches]        = in_sel;
        end
        latches++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  initial begin
    int          dcyc, lat, err_cyc, act;
    logic [11:0] idxs;
    logic [2:0]  sels;
    logic [31:0] snap;

    // Reset state
    tick();
    tick();
    check_val("reset_outs", outs(), 32'h0);
    rst = 1'b1;
    tick();
    check_val("idle_outs", outs(), 32'h0);

    // Single layer at minimum latency: LOAD 1-2, RUN 3-4, CAPTURE 5, FIN 6
    run_job(4'd1, 1, 1'b0, dcyc, lat, idxs, sels);
    check_val("min_lat_done_cyc", dcyc, 32'd6);
    check_val("min_lat_latches", lat, 32'd1);
    check_val("min_lat_busy_fin", busy, 1'b0);
    tick();
    check_val("min_lat_after", outs(), 32'h0);

    // Three layers, engine done 5 cycles after enable, stray start at cycle 5
    run_job(4'd3, 5, 1'b1, dcyc, lat, idxs, sels);
    check_val("l3_done_cyc", dcyc, 32'd28);
    check_val("l3_latches", lat, 32'd3);
    check_val("l3_idx_seq", idxs, 12'h210);
    check_val("l3_sel_seq", sels, 3'b110);
    tick();
    check_val("l3_idle_busy", busy, 1'b0);
    check_val("l3_idle_insel", in_sel, 1'b0);
    act = 0;
    repeat (10) begin
      if (busy || done || out_latch || err) act++;
      tick();
    end
    check_val("l3_no_queued_start", act, 32'd0);

    // Illegal layer counts: err one cycle after start, busy never high
    num_layers = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("nl0_err", {busy, err}, 2'b01);
    tick();
    check_val("nl0_err_gone", {busy, err}, 2'b00);
    num_layers = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("nl9_err", {busy, err}, 2'b01);
    act = 0;
    repeat (5) begin
      tick();
      if (busy || err) act++;
    end
    check_val("nl9_quiet", act, 32'd0);

    // lin_done held high into RUN: capture only after a fresh rising edge
    ovr_en = 1'b1;
    ovr_val = 1'b1;
    num_layers = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 11; c++) begin
      if (out_latch) lat++;
      tick();
    end
    if (out_latch) lat++;
    ovr_val = 1'b0;
    tick();
    if (out_latch) lat++;
    ovr_val = 1'b1;
    check_val("held_no_capture", lat, 32'd0);
    check_val("held_still_run", {busy, lin_enable}, 2'b11);
    tick();
    check_val("held_capture", {out_latch, lin_enable}, 2'b10);
    tick();
    check_val("held_done", {done, busy}, 2'b10);
    ovr_en = 1'b0;
    tick();

    // Reset in the middle of layer 2's RUN
    num_layers = 4'd3;
    eng_dly = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    check_val("mid_run_state", {layer_idx, lin_enable, busy}, 6'b0001_1_1);
    rst = 1'b0;
    #1;
    check_val("mid_run_reset_outs", outs(), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    act = 0;
    repeat (6) begin
      tick();
      if (busy || done || err) act++;
    end
    check_val("post_reset_quiet", act, 32'd0);
    run_job(4'd1, 1, 1'b0, dcyc, lat, idxs, sels);
    check_val("post_reset_job", dcyc, 32'd6);
    tick();

    // Engine that never finishes
    num_layers = 4'd1;
    eng_dly = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    err_cyc = -1;
    snap = '0;
    for (int c = 1; c <= 110; c++) begin
      if (err && err_cyc < 0) begin
        err_cyc = c;
        snap = outs();
      end
      tick();
    end
`ifdef LINSEQ_TIMEOUT_EN
    check_val("timeout_err_cyc", err_cyc, 32'd19);
    check_val("timeout_outs", snap, 32'h140);
    check_val("timeout_idle", {busy, lin_rst, lin_enable}, 3'b000);
`else
    check_val("no_timeout_err", err_cyc, 32'hFFFF_FFFF);
    check_val("no_timeout_run", {busy, lin_enable, err}, 3'b110);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_val("no_timeout_reset", outs(), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
